// File: rtl/decimal_entry_pkg.sv
// Shared types, constants and BCD helpers for the decimal entry controller.
package decimal_entry_pkg;

   typedef enum logic [1:0] {IDLE, CONVERT, DONE} entry_state_t;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned CONV_STEPS = 16;

   typedef logic [3:0] bcd_digit_t;

   localparam int unsigned BTN_UP    = 0;
   localparam int unsigned BTN_DOWN  = 1;
   localparam int unsigned BTN_LEFT  = 2;
   localparam int unsigned BTN_RIGHT = 3;
   localparam int unsigned BTN_ENTER = 4;
   localparam int unsigned NUM_BTNS  = 5;

   function automatic bcd_digit_t digit_inc(input bcd_digit_t d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

   function automatic bcd_digit_t digit_dec(input bcd_digit_t d);
      return (d == 4'd0) ? 4'd9 : d - 4'd1;
   endfunction

   // One reverse double-dabble step: shift right, then correct BCD nibbles >= 8.
   function automatic logic [31:0] dabble_step(input logic [31:0] w);
      logic [31:0] r;
      r = w >> 1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (r[16 + i*4 +: 4] >= 4'd8)
            r[16 + i*4 +: 4] = r[16 + i*4 +: 4] - 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stability counter; emits a one-cycle pulse on an accepted press.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
            press <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/decimal_entry_ctrl.sv
// Debounced 4-digit BCD editor with cursor; Enter converts the digits to binary
// via a 16-step reverse double-dabble and pulses data_valid.
module decimal_entry_ctrl
   import decimal_entry_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_enter,
   output logic [15:0] bcd_out,
   output logic [1:0]  cursor,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic        busy
);

   logic [NUM_BTNS-1:0] raw;
   logic [NUM_BTNS-1:0] press;

   entry_state_t state, state_next;
   bcd_digit_t   digits [NUM_DIGITS];
   logic [1:0]   cursor_q;
   logic [31:0]  work, work_next;
   logic [4:0]   step;
   logic [15:0]  data_q;
   logic         last_step;

   always_comb begin
      raw            = '0;
      raw[BTN_UP]    = btn_up;
      raw[BTN_DOWN]  = btn_down;
      raw[BTN_LEFT]  = btn_left;
      raw[BTN_RIGHT] = btn_right;
      raw[BTN_ENTER] = btn_enter;
   end

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .reset (reset),
         .btn   (raw[i]),
         .press (press[i])
      );
   end

   assign work_next = dabble_step(work);
   assign last_step = (step == 5'(CONV_STEPS - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (press[BTN_ENTER]) state_next = CONVERT;
         CONVERT: if (last_step)        state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      data_valid = (state == DONE);
   end

   // Presses outside IDLE fall through untouched, so nothing is queued while busy.
   // data_out is loaded on the final step so it is already valid in the DONE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
         cursor_q <= '0;
         work     <= '0;
         step     <= '0;
         data_q   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (press[BTN_ENTER]) begin
                  work <= {bcd_out, 16'h0000};
                  step <= '0;
               end else if (press[BTN_UP]) begin
                  digits[cursor_q] <= digit_inc(digits[cursor_q]);
               end else if (press[BTN_DOWN]) begin
                  digits[cursor_q] <= digit_dec(digits[cursor_q]);
               end else if (press[BTN_LEFT]) begin
                  cursor_q <= cursor_q + 2'd1;
               end else if (press[BTN_RIGHT]) begin
                  cursor_q <= cursor_q - 2'd1;
               end
            end
            CONVERT: begin
               work <= work_next;
               step <= step + 5'd1;
               if (last_step) data_q <= work_next[15:0];
            end
            default: ;
         endcase
      end
   end

   assign bcd_out  = {digits[3], digits[2], digits[1], digits[0]};
   assign cursor   = cursor_q;
   assign data_out = data_q;

endmodule

// File: tb/tb_decimal_entry_ctrl.sv
// Directed bench for decimal_entry_ctrl with a scoreboard checking each conversion result and its timing.
module tb_decimal_entry_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_enter = 1'b0;
   logic [15:0] bcd_out, data_out;
   logic [1:0]  cursor;
   logic        data_valid, busy;

   typedef struct {
      logic [15:0] data;
      int unsigned at;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   int unsigned busy_run = 0;
   logic        prev_valid = 1'b0;

   decimal_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_enter  (btn_enter),
      .bcd_out    (bcd_out),
      .cursor     (cursor),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input int idx, input logic v);
      case (idx)
         0: btn_up    = v;
         1: btn_down  = v;
         2: btn_left  = v;
         3: btn_right = v;
         default: btn_enter = v;
      endcase
   endtask

   task automatic press_btn(input int idx);
      set_btn(idx, 1'b1);
      tick(8);
      set_btn(idx, 1'b0);
      tick(8);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected results never presented, required 0", sb.size());
         sb.delete();
      end
      tick(4);
   endtask

   // Enter pulse lands 6 cycles after the raw edge; data_valid follows 17 cycles later.
   task automatic do_enter(input logic [15:0] exp);
      sb.push_back('{exp, cyc + 23});
      btn_enter = 1'b1;
      tick(8);
      btn_enter = 1'b0;
      wait_drain();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         busy_run   = 0;
         prev_valid = 1'b0;
      end else begin
         if (data_valid) begin
            check("valid_width", prev_valid, 1'b0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got data_out=%0h at cycle %0d, required no valid", data_out, cyc);
            end else begin
               e = sb.pop_front();
               check("data_out", data_out, e.data);
               check("valid_cycle", cyc, e.at);
            end
         end
         if (busy) busy_run++;
         else if (busy_run != 0) begin
            check("busy_len", busy_run, 17);
            busy_run = 0;
         end
         prev_valid = data_valid;
      end
   end

   initial begin
      int unsigned k;
      tick(3);
      reset = 1'b0;
      tick(1);
      // 1: reset values, convert zero
      check("rst_bcd", bcd_out, 16'h0000);
      check("rst_cursor", cursor, 2'd0);
      check("rst_data", data_out, 16'h0000);
      check("rst_valid", data_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      do_enter(16'd0);

      // 2: three ups
      for (int i = 0; i < 3; i++) press_btn(0);
      check("up3_bcd", bcd_out, 16'h0003);
      do_enter(16'd3);

      // 3: 9999 via down + left, cursor wraps
      do_reset();
      for (int i = 0; i < 4; i++) begin
         press_btn(1);
         press_btn(2);
      end
      check("nines_bcd", bcd_out, 16'h9999);
      check("left_wrap", cursor, 2'd0);
      do_enter(16'h270F);

      // 4: 25, then down wraps 0 -> 9, right wraps 0 -> 3
      do_reset();
      press_btn(2);
      press_btn(0);
      press_btn(0);
      check("tens_bcd", bcd_out, 16'h0020);
      press_btn(3);
      for (int i = 0; i < 5; i++) press_btn(0);
      check("t25_bcd", bcd_out, 16'h0025);
      do_enter(16'd25);
      press_btn(2);
      press_btn(2);
      press_btn(1);
      check("down_wrap", bcd_out, 16'h0925);
      for (int i = 0; i < 3; i++) press_btn(3);
      check("right_wrap", cursor, 2'd3);

      // 5: glitch ignored, bounced press counted once
      btn_up = 1'b1;
      tick(2);
      btn_up = 1'b0;
      tick(10);
      check("glitch_bcd", bcd_out, 16'h0925);
      for (int i = 0; i < 3; i++) begin
         btn_up = 1'b1;
         tick(1);
         btn_up = 1'b0;
         tick(1);
      end
      press_btn(0);
      check("bounce_bcd", bcd_out, 16'h1925);

      // 6: press during conversion is discarded
      sb.push_back('{16'h0785, cyc + 23});
      btn_enter = 1'b1;
      tick(5);
      btn_up = 1'b1;
      tick(10);
      btn_up = 1'b0;
      btn_enter = 1'b0;
      wait_drain();
      tick(10);
      check("busy_ignore_bcd", bcd_out, 16'h1925);
      check("busy_ignore_cur", cursor, 2'd3);

      // 6b: reset mid-conversion; enter held through reset must be re-accepted
      k = cyc;
      btn_enter = 1'b1;
      tick(14);
      check("abort_busy_pre", busy, 1'b1);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      k = cyc;
      sb.push_back('{16'h0000, k + 23});
      #1;
      check("abort_data", data_out, 16'h0000);
      check("abort_bcd", bcd_out, 16'h0000);
      check("abort_cursor", cursor, 2'd0);
      check("abort_busy", busy, 1'b0);
      check("abort_valid", data_valid, 1'b0);
      tick(8);
      btn_enter = 1'b0;
      wait_drain();
      tick(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decimal_entry_ctrl.md
Name: decimal_entry_ctrl

Overview:
Operator-side counterpart to the 4-digit decimal display path. Debounces five board push-buttons and lets the user edit a 4-digit decimal value (0..9999) with a cursor. On Enter, it converts the packed BCD digits to a 16-bit binary word using a sequential reverse double-dabble, then pulses data_valid. bcd_out and cursor feed back to the display path for echo.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples needed to accept a button level (10 ms at 100 MHz)
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_up  in  1  raw async button: increment digit at cursor
btn_down  in  1  raw async button: decrement digit at cursor
btn_left  in  1  raw async button: move cursor toward thousands
btn_right  in  1  raw async button: move cursor toward units
btn_enter  in  1  raw async button: start conversion
bcd_out  out  16  {thousands,hundreds,tens,units}, 4 bits each
cursor  out  2  selected digit, 0=units .. 3=thousands
data_out  out  16  converted binary value, held until next conversion
data_valid  out  1  one-cycle pulse when data_out updates
busy  out  1  high while converting

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: bcd_out=0, cursor=0, data_out=0, data_valid=0, busy=0, FSM=IDLE. Every debouncer resets to released (level 0, counter 0).
- Debounce, per button:
  - 2-flop synchronizer feeds the debounce logic.
  - Counter clears whenever the synced sample equals the accepted level.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
  - A 0->1 transition of the accepted level produces a one-cycle press pulse. No pulse on release, and no auto-repeat.
- Editing, IDLE only, at most one action per cycle. Priority: enter > up > down > left > right; lower-priority pulses in the same cycle are dropped.
  - up: digit[cursor] +1, wraps 9->0.
  - down: digit[cursor] -1, wraps 0->9.
  - left: cursor +1, wraps 3->0.
  - right: cursor -1, wraps 0->3.
  - Digits are always 0..9; no other value is reachable.
- FSM states IDLE, CONVERT, DONE:
  - IDLE, enter pulse: load work[31:0] = {bcd_out, 16'h0}, clear step counter, go to CONVERT, busy=1 next cycle.
  - CONVERT, each cycle: shift work right by 1 (zero fill into bit 31), then subtract 3 from each nibble of work[31:16] that is >=8. Exactly 16 steps.
  - After step 16: go to DONE.
  - DONE: data_out <= work[15:0], data_valid=1 for that cycle only, then IDLE with busy=0.
  - Latency: data_valid is high exactly 17 cycles after the cycle the enter pulse is high.
- While busy (CONVERT or DONE), all press pulses, including enter, are discarded, not queued. Digits and cursor hold.
- data_out is stable except in the DONE cycle. Max result is 9999 (0x270F), so bits 15:14 are always 0.
- Reset mid-conversion aborts immediately:
  - No data_valid is produced.
  - All outputs return to reset values.
  - Debouncers restart, so a button held through reset must be re-accepted before it generates a press.

Decomposition:
- Package decimal_entry_pkg:
  - typedef enum logic [1:0] entry_state_t {IDLE, CONVERT, DONE}
  - NUM_DIGITS=4, CONV_STEPS=16
  - typedef logic [3:0] bcd_digit_t
  - button index constants BTN_UP..BTN_ENTER
- Sub-module button_debouncer (synchronizer + counter + press pulse, parameter DEBOUNCE_CYCLES), instantiated five times.
- The top level holds the edit logic and the conversion FSM.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset -> bcd_out=0x0000, cursor=0, data_out=0, data_valid=0, busy=0. Enter with no edits -> data_valid after 17 cycles, data_out=0.
2. Three clean btn_up presses -> bcd_out=0x0003. Enter -> busy high for 17 cycles; data_valid pulse of exactly 1 cycle with data_out=16'd3.
3. btn_down once per digit, moving the cursor with btn_left -> bcd_out=0x9999, cursor wraps 3->0 on the 4th left. Enter -> data_out=0x270F.
4. Cursor at tens: up x2 -> 0x0020; right; up x5 -> 0x0025. Enter -> data_out=16'd25. Down on a digit at 0 -> 9.
5. 2-cycle glitch on btn_up, and a press bouncing 3 times within 3 cycles then settling -> glitch gives no change; bounced press increments exactly once.
6. Enter, then btn_up press at cycle +5 -> increment ignored and no second conversion. Reset asserted at cycle +8 of a second conversion -> no data_valid, data_out=0, bcd_out=0.
